// File: rtl/sys_ctrl_seq_regs.sv
// Per-core clock/reset/boot/PLL control registers with a hardware power-up sequencer per core.
// Memory-mapped: core c at 0x10*c, sequencer status at 0x800.
module sys_ctrl_seq_regs #(
  parameter int unsigned NUM_CORES     = 4,
  parameter int unsigned ADDR_WIDTH    = 12,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned LOCK_TIMEOUT  = 1024,
  parameter int unsigned RST_DELAY     = 16,
  parameter logic [31:0] BOOT_ADDR_RST = 32'h0000_0000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    mem_we_i,
  input  logic [ADDR_WIDTH-1:0]   mem_waddr_i,
  input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
  input  logic [3:0]              mem_wstrb_i,
  output logic [1:0]              mem_wresp_o,
  input  logic                    mem_re_i,
  input  logic [ADDR_WIDTH-1:0]   mem_raddr_i,
  output logic [DATA_WIDTH-1:0]   mem_rdata_o,
  output logic [1:0]              mem_rresp_o,
  output logic [NUM_CORES-1:0]    core_clk_en_o,
  output logic [NUM_CORES-1:0]    core_rst_no,
  output logic [NUM_CORES*32-1:0] boot_addr_o,
  output logic [NUM_CORES*32-1:0] boot_hartid_o,
  output logic [NUM_CORES*4-1:0]  pll_ref_div_o,
  output logic [NUM_CORES*12-1:0] pll_fb_div_o,
  input  logic [NUM_CORES-1:0]    pll_locked_i
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLock = 3'd1,
    StClk  = 3'd2,
    StDone = 3'd3,
    StErr  = 3'd4
  } seq_state_e;

  localparam int unsigned CntMax = (LOCK_TIMEOUT > RST_DELAY) ? LOCK_TIMEOUT : RST_DELAY;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] CntSat   = CntW'(CntMax);
  localparam logic [CntW-1:0] LockLast = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0] RstLast  = CntW'(RST_DELAY - 1);
  localparam logic [ADDR_WIDTH-1:0] StatusAddr = ADDR_WIDTH'('h800);

  logic [31:0]     boot_q [NUM_CORES];
  logic [31:0]     boot_d [NUM_CORES];
  logic [31:0]     hart_q [NUM_CORES];
  logic [31:0]     hart_d [NUM_CORES];
  logic [3:0]      ref_div_q [NUM_CORES];
  logic [3:0]      ref_div_d [NUM_CORES];
  logic [11:0]     fb_div_q [NUM_CORES];
  logic [11:0]     fb_div_d [NUM_CORES];
  seq_state_e      state_q [NUM_CORES];
  seq_state_e      state_d [NUM_CORES];
  logic [CntW-1:0] cnt_q [NUM_CORES];
  logic [CntW-1:0] cnt_d [NUM_CORES];
  logic [NUM_CORES-1:0] clk_en_q, clk_en_d, rst_n_q, rst_n_d, done_q, done_d, err_q, err_d;

  logic [31:0] w_idx, r_idx, wmask, status;
  logic [1:0]  w_reg, r_reg;
  logic        w_is_core, w_busy, w_ok, wr, start, manual;
  logic [15:0] pll_new;

  assign w_idx = 32'(mem_waddr_i[ADDR_WIDTH-1:4]);
  assign r_idx = 32'(mem_raddr_i[ADDR_WIDTH-1:4]);
  assign w_reg = mem_waddr_i[3:2];
  assign r_reg = mem_raddr_i[3:2];
  assign wmask = {{8{mem_wstrb_i[3]}}, {8{mem_wstrb_i[2]}}, {8{mem_wstrb_i[1]}},
                  {8{mem_wstrb_i[0]}}};

  // Write decode; CTRL/PLL_CFG are locked out while the sequencer owns the core.
  always_comb begin
    w_is_core = mem_we_i && (mem_waddr_i[1:0] == 2'b00) && (w_idx < NUM_CORES);
    w_busy    = 1'b0;
    for (int c = 0; c < NUM_CORES; c++) begin
      if (w_idx == 32'(c)) w_busy = (state_q[c] == StLock) || (state_q[c] == StClk);
    end
    w_ok        = w_is_core && !(w_busy && (w_reg == 2'd0 || w_reg == 2'd3));
    mem_wresp_o = (mem_we_i && !w_ok) ? 2'b10 : 2'b00;
  end

  always_comb begin
    boot_d    = boot_q;
    hart_d    = hart_q;
    ref_div_d = ref_div_q;
    fb_div_d  = fb_div_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    clk_en_d  = clk_en_q;
    rst_n_d   = rst_n_q;
    done_d    = done_q;
    err_d     = err_q;
    pll_new   = '0;
    wr        = 1'b0;
    start     = 1'b0;
    manual    = 1'b0;
    for (int c = 0; c < NUM_CORES; c++) begin
      wr     = w_ok && (w_idx == 32'(c));
      start  = wr && (w_reg == 2'd0) && mem_wstrb_i[0] && mem_wdata_i[2];
      manual = wr && (w_reg == 2'd0) && mem_wstrb_i[0] && !mem_wdata_i[2];
      if (wr && w_reg == 2'd1) boot_d[c] = (boot_q[c] & ~wmask) | (mem_wdata_i & wmask);
      if (wr && w_reg == 2'd2) hart_d[c] = (hart_q[c] & ~wmask) | (mem_wdata_i & wmask);
      if (wr && w_reg == 2'd3) begin
        pll_new = ({fb_div_q[c], ref_div_q[c]} & ~wmask[15:0]) |
                  (mem_wdata_i[15:0] & wmask[15:0]);
        ref_div_d[c] = pll_new[3:0];
        fb_div_d[c]  = pll_new[15:4];
      end
      case (state_q[c])
        StLock: begin
          if (pll_locked_i[c]) begin
            state_d[c]  = StClk;
            clk_en_d[c] = 1'b1;
            cnt_d[c]    = '0;
          end else if (cnt_q[c] == LockLast) begin
            state_d[c]  = StErr;
            clk_en_d[c] = 1'b0;
            rst_n_d[c]  = 1'b0;
            err_d[c]    = 1'b1;
          end else begin
            cnt_d[c] = (cnt_q[c] == CntSat) ? cnt_q[c] : cnt_q[c] + CntW'(1);
          end
        end
        StClk: begin
          if (!pll_locked_i[c]) begin
            state_d[c]  = StErr;
            clk_en_d[c] = 1'b0;
            rst_n_d[c]  = 1'b0;
            err_d[c]    = 1'b1;
          end else if (cnt_q[c] == RstLast) begin
            state_d[c] = StDone;
            rst_n_d[c] = 1'b1;
            done_d[c]  = 1'b1;
          end else begin
            cnt_d[c] = (cnt_q[c] == CntSat) ? cnt_q[c] : cnt_q[c] + CntW'(1);
          end
        end
        default: begin
          if (start) begin
            state_d[c]  = StLock;
            clk_en_d[c] = 1'b0;
            rst_n_d[c]  = 1'b0;
            done_d[c]   = 1'b0;
            err_d[c]    = 1'b0;
            cnt_d[c]    = '0;
          end else if (manual) begin
            clk_en_d[c] = mem_wdata_i[0];
            rst_n_d[c]  = mem_wdata_i[1];
          end
        end
      endcase
    end
  end

  always_comb begin
    status      = '0;
    mem_rdata_o = '0;
    mem_rresp_o = 2'b00;
    for (int c = 0; c < NUM_CORES; c++) begin
      status[c]      = done_q[c];
      status[16 + c] = err_q[c];
    end
    if (mem_re_i) begin
      if (mem_raddr_i == StatusAddr) begin
        mem_rdata_o = status;
      end else if (mem_raddr_i[1:0] == 2'b00 && r_idx < NUM_CORES) begin
        for (int c = 0; c < NUM_CORES; c++) begin
          if (r_idx == 32'(c)) begin
            case (r_reg)
              2'd0: mem_rdata_o = {22'd0, err_q[c], done_q[c], 1'b0, state_q[c], 2'b00,
                                   rst_n_q[c], clk_en_q[c]};
              2'd1: mem_rdata_o = boot_q[c];
              2'd2: mem_rdata_o = hart_q[c];
              default: mem_rdata_o = {15'd0, pll_locked_i[c], fb_div_q[c], ref_div_q[c]};
            endcase
          end
        end
      end else begin
        mem_rresp_o = 2'b10;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CORES; c++) begin
      boot_addr_o[32*c +: 32]   = boot_q[c];
      boot_hartid_o[32*c +: 32] = hart_q[c];
      pll_ref_div_o[4*c +: 4]   = ref_div_q[c];
      pll_fb_div_o[12*c +: 12]  = fb_div_q[c];
    end
  end

  assign core_clk_en_o = clk_en_q;
  assign core_rst_no   = rst_n_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int c = 0; c < NUM_CORES; c++) begin
        boot_q[c]    <= BOOT_ADDR_RST;
        hart_q[c]    <= 32'(c);
        ref_div_q[c] <= '0;
        fb_div_q[c]  <= '0;
        state_q[c]   <= StIdle;
        cnt_q[c]     <= '0;
      end
      clk_en_q <= '0;
      rst_n_q  <= '0;
      done_q   <= '0;
      err_q    <= '0;
    end else begin
      boot_q    <= boot_d;
      hart_q    <= hart_d;
      ref_div_q <= ref_div_d;
      fb_div_q  <= fb_div_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clk_en_q  <= clk_en_d;
      rst_n_q   <= rst_n_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_sys_ctrl_seq_regs.sv
// Directed bench for sys_ctrl_seq_regs: register access, strobes, sequencer timing, errors, reset.
module tb_sys_ctrl_seq_regs;
  localparam int unsigned LT = 40;
  localparam int unsigned RD = 5;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         mem_we_i, mem_re_i;
  logic [11:0]  mem_waddr_i, mem_raddr_i;
  logic [31:0]  mem_wdata_i, mem_rdata_o;
  logic [3:0]   mem_wstrb_i;
  logic [1:0]   mem_wresp_o, mem_rresp_o;
  logic [3:0]   core_clk_en_o, core_rst_no, pll_locked_i;
  logic [127:0] boot_addr_o, boot_hartid_o;
  logic [15:0]  pll_ref_div_o;
  logic [47:0]  pll_fb_div_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] rdat;
  logic [1:0]  resp;

  sys_ctrl_seq_regs #(
    .NUM_CORES(4), .ADDR_WIDTH(12), .DATA_WIDTH(32), .LOCK_TIMEOUT(LT), .RST_DELAY(RD),
    .BOOT_ADDR_RST(32'h0000_0000)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .mem_we_i(mem_we_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
    .mem_wstrb_i(mem_wstrb_i), .mem_wresp_o(mem_wresp_o),
    .mem_re_i(mem_re_i), .mem_raddr_i(mem_raddr_i), .mem_rdata_o(mem_rdata_o),
    .mem_rresp_o(mem_rresp_o),
    .core_clk_en_o(core_clk_en_o), .core_rst_no(core_rst_no),
    .boot_addr_o(boot_addr_o), .boot_hartid_o(boot_hartid_o),
    .pll_ref_div_o(pll_ref_div_o), .pll_fb_div_o(pll_fb_div_o),
    .pll_locked_i(pll_locked_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                    output logic [1:0] r);
    mem_we_i = 1'b1; mem_waddr_i = a; mem_wdata_i = d; mem_wstrb_i = s;
    #1 r = mem_wresp_o;
    tick();
    mem_we_i = 1'b0; mem_wstrb_i = 4'h0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d, output logic [1:0] r);
    mem_re_i = 1'b1; mem_raddr_i = a;
    #1 begin d = mem_rdata_o; r = mem_rresp_o; end
    tick();
    mem_re_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; mem_we_i = 1'b0; mem_re_i = 1'b0; mem_waddr_i = '0; mem_raddr_i = '0;
    mem_wdata_i = '0; mem_wstrb_i = '0; pll_locked_i = 4'b1010;
    repeat (3) tick();
    rst_ni = 1'b1;

    chk("rst_clk_en", core_clk_en_o, 4'h0);
    chk("rst_rst_n", core_rst_no, 4'h0);
    chk("rst_boot", boot_addr_o, 128'h0);
    chk("rst_hartid", boot_hartid_o, {32'd3, 32'd2, 32'd1, 32'd0});
    chk("rst_div", {pll_ref_div_o, pll_fb_div_o}, 64'h0);
    chk("idle_resp", {mem_wresp_o, mem_rresp_o, mem_rdata_o}, 36'h0);
    for (int c = 0; c < 4; c++) begin
      rd(12'(16 * c), rdat, resp);      chk("rst_ctrl", rdat, 32'h0);
      rd(12'(16 * c + 4), rdat, resp);  chk("rst_boot_rd", rdat, 32'h0);
      rd(12'(16 * c + 8), rdat, resp);  chk("rst_hart_rd", rdat, 32'(c));
      rd(12'(16 * c + 12), rdat, resp); chk("rst_pll_rd", rdat, {15'd0, pll_locked_i[c], 16'd0});
    end

    // Byte strobes
    wr(12'h014, 32'hDEAD_BEEF, 4'b0101, resp); chk("boot_wresp", resp, 2'b00);
    rd(12'h014, rdat, resp);
    chk("boot_strb_rd", rdat, 32'h00AD_00EF);
    chk("boot_strb_rresp", resp, 2'b00);
    chk("boot_strb_out", boot_addr_o[63:32], 32'h00AD_00EF);

    // Simultaneous read and write returns the old value
    mem_we_i = 1'b1; mem_waddr_i = 12'h038; mem_wdata_i = 32'h55; mem_wstrb_i = 4'hF;
    mem_re_i = 1'b1; mem_raddr_i = 12'h038;
    #1 rdat = mem_rdata_o;
    tick();
    mem_we_i = 1'b0; mem_re_i = 1'b0; mem_wstrb_i = 4'h0;
    chk("rw_old", rdat, 32'd3);
    rd(12'h038, rdat, resp); chk("rw_new", rdat, 32'h55);

    // Core 0 power-up sequence, lock raised in cycle 3
    wr(12'h00C, 32'h0000_1233, 4'hF, resp);
    rd(12'h00C, rdat, resp); chk("pll_rd", rdat, 32'h0000_1233);
    chk("pll_out", {pll_ref_div_o[3:0], pll_fb_div_o[11:0]}, {4'h3, 12'h123});
    wr(12'h000, 32'h4, 4'h1, resp);              // cycle 0 -> now cycle 1
    rd(12'h000, rdat, resp); chk("c0_lock_state", rdat, 32'h10);  // now cycle 2
    tick();                                       // cycle 3
    pll_locked_i[0] = 1'b1;
    chk("c0_clk_c3", core_clk_en_o[0], 1'b0);
    tick();                                       // cycle 4
    chk("c0_clk_c4", {core_clk_en_o[0], core_rst_no[0]}, 2'b10);
    repeat (RD - 1) tick();                       // cycle 4+RD-1
    chk("c0_rst_early", core_rst_no[0], 1'b0);
    tick();                                       // cycle 4+RD
    chk("c0_rst_rel", {core_clk_en_o[0], core_rst_no[0]}, 2'b11);
    rd(12'h000, rdat, resp); chk("c0_done_ctrl", rdat, 32'h133);
    rd(12'h800, rdat, resp); chk("c0_status", rdat, 32'h1);
    pll_locked_i[0] = 1'b0;
    tick();
    chk("c0_done_lockloss", {core_clk_en_o[0], core_rst_no[0]}, 2'b11);

    // Core 3 timeout
    pll_locked_i[3] = 1'b0;
    wr(12'h030, 32'h4, 4'h1, resp);              // now cycle 1
    repeat (LT - 1) tick();                       // cycle LT
    rd(12'h030, rdat, resp); chk("c3_pre_timeout", rdat, 32'h10);  // now cycle 1+LT
    chk("c3_err_outs", {core_clk_en_o[3], core_rst_no[3]}, 2'b00);
    rd(12'h030, rdat, resp); chk("c3_err_ctrl", rdat, 32'h240);
    rd(12'h800, rdat, resp); chk("c3_status", rdat, 32'h0008_0001);
    pll_locked_i[3] = 1'b1;
    wr(12'h030, 32'h4, 4'h1, resp);
    rd(12'h030, rdat, resp); chk("c3_restart", rdat, 32'h10);

    // Core 2 busy lockout
    wr(12'h020, 32'h4, 4'h1, resp);
    wr(12'h02C, 32'h0000_FFFF, 4'hF, resp); chk("c2_pll_busy", resp, 2'b10);
    wr(12'h020, 32'h3, 4'h1, resp);         chk("c2_ctrl_busy", resp, 2'b10);
    wr(12'h028, 32'h0000_ABCD, 4'hF, resp); chk("c2_hart_ok", resp, 2'b00);
    chk("c2_pll_unch", {pll_ref_div_o[11:8], pll_fb_div_o[35:24]}, 16'h0);
    chk("c2_clk_unch", core_clk_en_o[2], 1'b0);
    rd(12'h028, rdat, resp); chk("c2_hart_rd", rdat, 32'h0000_ABCD);
    rd(12'h02C, rdat, resp); chk("c2_pll_rd", rdat, 32'h0);

    // Manual control of idle core 1
    wr(12'h010, 32'h3, 4'h1, resp);
    chk("c1_manual", {core_clk_en_o[1], core_rst_no[1]}, 2'b11);
    rd(12'h010, rdat, resp); chk("c1_manual_rd", rdat, 32'h3);

    // Unmapped and read-only accesses
    rd(12'h0F0, rdat, resp); chk("unm_rd_core", {resp, rdat}, {2'b10, 32'h0});
    wr(12'h0F0, 32'h1, 4'hF, resp); chk("unm_wr_core", resp, 2'b10);
    rd(12'h002, rdat, resp); chk("unm_rd_align", {resp, rdat}, {2'b10, 32'h0});
    wr(12'h800, 32'hFFFF_FFFF, 4'hF, resp); chk("ro_wr_status", resp, 2'b10);
    #1;
    chk("noacc", {mem_wresp_o, mem_rresp_o, mem_rdata_o}, 36'h0);
    rd(12'h800, rdat, resp); chk("status_ok", resp, 2'b00);

    // Reset in the middle of core 2's CLK phase
    pll_locked_i[2] = 1'b1;
    tick();
    chk("c2_clk_on", core_clk_en_o[2], 1'b1);
    rst_ni = 1'b0;
    tick();
    chk("mid_rst_clk", core_clk_en_o, 4'h0);
    chk("mid_rst_rst", core_rst_no, 4'h0);
    chk("mid_rst_boot", boot_addr_o, 128'h0);
    chk("mid_rst_hart", boot_hartid_o, {32'd3, 32'd2, 32'd1, 32'd0});
    chk("mid_rst_div", {pll_ref_div_o, pll_fb_div_o}, 64'h0);
    rst_ni = 1'b1;
    rd(12'h020, rdat, resp); chk("post_rst_ctrl", rdat, 32'h0);
    rd(12'h02C, rdat, resp); chk("post_rst_pll", rdat, 32'h0001_0000);
    rd(12'h800, rdat, resp); chk("post_rst_status", rdat, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
